// File: rtl/rst_clken_seq_pkg.sv
// Shared definitions for rst_clken_seq: sequencer states, default parameters
// and the counter-width helper.
package rst_clken_pkg;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_STAGE_GAP   = 4;
    localparam int unsigned DEF_DIV_W       = 8;

    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        STAGE,
        RUN
    } seq_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_clken_seq_clken_div.sv
// Per-channel clock-enable divider: emits a one-cycle strobe every div_eff
// cycles once its channel reset is released, with freeze/step override.
module clken_div
    import rst_clken_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             freeze,
    input  logic             step,
    output logic             en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // A ratio of 0 behaves as 1.
    assign last = (div == '0) ? '0 : div - DIV_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (rst) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (freeze) begin
            en  <= step;
        end else if (cnt >= last) begin
            // >= so a ratio lowered below the running count wraps at once.
            cnt <= '0;
            en  <= 1'b1;
        end else begin
            cnt <= cnt + DIV_W'(1);
            en  <= 1'b0;
        end
    end

endmodule

// File: rtl/rst_clken_seq.sv
// Reset sequencer and clock-enable generator: synchronises reset release,
// releases N_CH channel resets in staggered order and drives per-channel
// divided enables. Single-step support is built when RST_CLKEN_STEP_EN is defined.
module rst_clken_seq
    import rst_clken_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP,
    parameter int unsigned DIV_W       = DEF_DIV_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH*DIV_W-1:0] div_i,
`ifdef RST_CLKEN_STEP_EN
    input  logic                  step_mode_i,
    input  logic                  step_i,
`endif
    output logic [N_CH-1:0]       rst_o,
    output logic [N_CH-1:0]       en_o,
    output logic                  ready_o
);

    localparam int unsigned HW = cnt_w(HOLD_CYCLES);
    localparam int unsigned GW = cnt_w(STAGE_GAP);
    localparam int unsigned IW = cnt_w(N_CH);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_CH - 1);

    seq_state_t      state;
    logic            sync1;
    logic            sync2;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nidx;
    logic [N_CH-1:0] rst_r;
    logic            ready_r;
    logic            rel0;
    logic            freeze;
    logic            step;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= 1'b1;
            sync2 <= sync1;
        end
    end

    // The edge that leaves SYNC is hold cycle 0, so channel 0 is released
    // exactly HOLD_CYCLES edges after the synchroniser output rises.
    always_comb begin
        rel0 = 1'b0;
        if (state == SYNC)
            rel0 = sync2 && (HOLD_CYCLES == 1);
        else if (state == HOLD)
            rel0 = (hold_cnt == HOLD_LAST);
    end

    assign nidx = idx + IW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SYNC;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            rst_r    <= '1;
            ready_r  <= 1'b0;
        end else if (rel0) begin
            rst_r[0] <= 1'b0;
            idx      <= '0;
            gap_cnt  <= '0;
            if (N_CH == 1) begin
                state   <= RUN;
                ready_r <= 1'b1;
            end else begin
                state <= STAGE;
            end
        end else begin
            case (state)
                SYNC: begin
                    if (sync2) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(1);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                STAGE: begin
                    if (gap_cnt == GAP_LAST) begin
                        rst_r[nidx] <= 1'b0;
                        idx         <= nidx;
                        gap_cnt     <= '0;
                        if (nidx == LAST_IDX) begin
                            state   <= RUN;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

`ifdef RST_CLKEN_STEP_EN
    assign freeze = step_mode_i && (state == RUN);
    assign step   = freeze && step_i;
`else
    assign freeze = 1'b0;
    assign step   = 1'b0;
`endif

    // Dividers use the synchronised reset so a reset glitch clears them too.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clken_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clock (clock),
            .reset (sync2),
            .rst   (rst_r[k]),
            .div   (div_i[k*DIV_W +: DIV_W]),
            .freeze(freeze),
            .step  (step),
            .en    (en_o[k])
        );
    end

    assign rst_o   = rst_r;
    assign ready_o = ready_r;

endmodule

// File: tb/tb_rst_clken_seq.sv
// Directed self-checking bench for rst_clken_seq (default build, plus a
// minimal configuration instance and the optional single-step mode).
module tb_rst_clken_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] div_i = 32'h01010101;
    logic        step_mode_i = 1'b0;
    logic        step_i = 1'b0;
    logic [3:0]  rst_o;
    logic [3:0]  en_o;
    logic        ready_o;
    logic [7:0]  div2 = 8'd1;
    logic [0:0]  rst2;
    logic [0:0]  en2;
    logic        ready2;

    int n_cmp  = 0;
    int n_err  = 0;
    int ecount = 0;

    always #5 clock = ~clock;

    rst_clken_seq dut (
        .clock      (clock),
        .reset      (reset),
        .div_i      (div_i),
`ifdef RST_CLKEN_STEP_EN
        .step_mode_i(step_mode_i),
        .step_i     (step_i),
`endif
        .rst_o      (rst_o),
        .en_o       (en_o),
        .ready_o    (ready_o)
    );

    rst_clken_seq #(
        .N_CH       (1),
        .HOLD_CYCLES(1),
        .STAGE_GAP  (1),
        .DIV_W      (8)
    ) dut2 (
        .clock      (clock),
        .reset      (reset),
        .div_i      (div2),
`ifdef RST_CLKEN_STEP_EN
        .step_mode_i(1'b0),
        .step_i     (1'b0),
`endif
        .rst_o      (rst2),
        .en_o       (en2),
        .ready_o    (ready2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_rst(input int e);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e < 18 + 4 * k);
        return r;
    endfunction

    function automatic logic [3:0] exp_en(input int e, input logic [31:0] d);
        logic [3:0] r;
        int rel;
        int dv;
        for (int k = 0; k < 4; k++) begin
            rel = 18 + 4 * k;
            dv  = int'(d[k*8 +: 8]);
            if (dv == 0) dv = 1;
            r[k] = (e > rel) && (((e - rel) % dv) == 0);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        ecount++;
    endtask

    task automatic do_reset(input logic [31:0] d);
        reset = 1'b0;
        div_i = d;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b1;
        ecount = 0;
    endtask

    task automatic run_seq(input int last);
        int e;
        while (ecount < last) begin
            tick();
            e = ecount;
            chk($sformatf("rst_o e%0d", e), 32'(rst_o), 32'(exp_rst(e)));
            chk($sformatf("en_o e%0d", e), 32'(en_o), 32'(exp_en(e, div_i)));
            chk($sformatf("ready_o e%0d", e), 32'(ready_o), 32'(e >= 30));
            chk($sformatf("min rst e%0d", e), 32'(rst2), 32'(e < 3));
            chk($sformatf("min ready e%0d", e), 32'(ready2), 32'(e >= 3));
            chk($sformatf("min en e%0d", e), 32'(en2), 32'(e >= 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d compared expected completion", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] pat;
        int e;

        #12;
        chk("reset rst_o", 32'(rst_o), 32'hF);
        chk("reset en_o", 32'(en_o), 32'h0);
        chk("reset ready_o", 32'(ready_o), 32'h0);
        chk("reset min rst", 32'(rst2), 32'h1);

        // Staggered release with every channel dividing by 1.
        do_reset(32'h01010101);
        run_seq(40);

        // Mixed ratios: ch0=3, ch1=0 (acts as 1), ch2=2, ch3=5.
        do_reset(32'h05020003);
        run_seq(50);

        // Short reset glitch after edge 25, then a full restart.
        do_reset(32'h01010101);
        run_seq(25);
        #1 reset = 1'b0;
        #2;
        chk("glitch rst_o", 32'(rst_o), 32'hF);
        chk("glitch en_o", 32'(en_o), 32'h0);
        chk("glitch ready_o", 32'(ready_o), 32'h0);
        chk("glitch min rst", 32'(rst2), 32'h1);
        #1 reset = 1'b1;
        ecount = 0;
        #1;
        chk("post glitch rst_o", 32'(rst_o), 32'hF);
        run_seq(32);

        // Ratio lowered below the running count: ch0 10 -> 4 at count 7.
        do_reset(32'h0101010A);
        while (ecount < 45) begin
            tick();
            e = ecount;
            chk($sformatf("div chg rst0 e%0d", e), 32'(rst_o[0]), 32'(e < 18));
            if (e >= 18)
                chk($sformatf("div chg en0 e%0d", e), 32'(en_o[0]),
                    32'((e == 28) || (e == 36) || (e == 40) || (e == 44)));
            if (e == 35) div_i[7:0] = 8'd4;
        end

`ifdef RST_CLKEN_STEP_EN
        div_i       = 32'h01010101;
        step_mode_i = 1'b1;
        tick();
        chk("step frozen en_o", 32'(en_o), 32'h0);
        pat = 8'b0101_0100;
        for (int i = 0; i < 8; i++) begin
            step_i = pat[i];
            tick();
            chk($sformatf("step en_o %0d", i), 32'(en_o), pat[i] ? 32'hF : 32'h0);
        end
        step_i      = 1'b0;
        step_mode_i = 1'b0;
        tick();
        chk("step resume en_o", 32'(en_o), 32'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
